// File: rtl/rf_pkg.sv
// rf_pkg: shared types and default sizing for the SISC register file.
//   rf_state_t : clear-sequencer state (RF_CLEAR, RF_IDLE)
//   RF_DATA_W, RF_DEPTH, RF_NRD : default width, depth and read-port count
package rf_pkg;

   typedef enum logic {
      RF_CLEAR,
      RF_IDLE
   } rf_state_t;

   localparam int RF_DATA_W = 32;
   localparam int RF_DEPTH  = 16;
   localparam int RF_NRD    = 2;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port of rf_multiport.
//   clk, rst  : clock, synchronous active-high reset
//   clearing  : file is being cleared; output loads zero
//   rd_addr   : read address
//   entry     : stored array entry at rd_addr (pre-edge value)
//   wr_fire   : write port is committing this cycle (already qualified)
//   wr_addr   : write address
//   wr_data   : write data, forwarded when BYPASS is set and addresses match
//   rd_data   : registered read data
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W  = RF_DATA_W,
   parameter int ADDR_W  = $clog2(RF_DEPTH),
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clearing,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] entry,
   input  logic              wr_fire,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   always_ff @(posedge clk) begin
      if (rst || clearing)
         rd_data <= '0;
      else if (ZERO_R0 != 0 && rd_addr == '0)
         rd_data <= '0;
      // wr_fire already excludes R0 and dropped writes, so forwarding
      // can never leak a write that the array itself refuses.
      else if (BYPASS != 0 && wr_fire && wr_addr == rd_addr)
         rd_data <= wr_data;
      else
         rd_data <= entry;
   end

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: parametrised multi-read, single-write register file with a
// hardware clear sequencer that zeroes every entry after reset or on request.
//   clk, rst : clock, synchronous active-high reset
//   rd_addr  : NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  : NRD packed registered read data, port i at [i*DATA_W +: DATA_W]
//   wr_addr, wr_data, wr_en : write port
//   clr_req  : single-cycle request to zero the whole file
//   busy     : clear sequencer running; writes are dropped
module rf_multiport
   import rf_pkg::*;
#(
   parameter int DATA_W  = RF_DATA_W,
   parameter int DEPTH   = RF_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int NRD     = RF_NRD,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  wr_en,
   input  logic                  clr_req,
   output logic                  busy
);

   rf_state_t         state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              clearing;
   logic              wr_fire;

   assign clearing = (state == RF_CLEAR);

   // A write commits only in IDLE, not alongside a clear request, and never
   // to R0 when it is hard-wired.
   assign wr_fire = !clearing && wr_en && !clr_req &&
                    !(ZERO_R0 != 0 && wr_addr == '0);

   // Clear sequencer: one entry per cycle, busy mirrors the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RF_CLEAR;
         ptr   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            RF_CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == ADDR_W'(DEPTH - 1)) begin
                  state <= RF_IDLE;
                  busy  <= 1'b0;
               end
            end
            RF_IDLE: begin
               if (clr_req) begin
                  state <= RF_CLEAR;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= RF_CLEAR;
               ptr   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage has no reset of its own; the sequencer zeroes it after rst.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clearing)
            mem[ptr] <= '0;
         else if (wr_fire)
            mem[wr_addr] <= wr_data;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] ent;

      assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
      assign ent = mem[ra];

      rf_read_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_R0 (ZERO_R0),
         .BYPASS  (BYPASS)
      ) u_rd (
         .clk      (clk),
         .rst      (rst),
         .clearing (clearing),
         .rd_addr  (ra),
         .entry    (ent),
         .wr_fire  (wr_fire),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rd_data  (rd_data[i*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: scoreboard bench for rf_multiport. Two instances share
// clk/rst: dut_a uses the defaults (32b x 16, 2 ports, ZERO_R0, BYPASS);
// dut_b is 64b x 32, 3 ports, no hard-wired R0, no bypass.
// Stimulus runs on the falling edge and queues expected values tagged with
// the cycle they must appear; the monitor checks them 1 time unit after
// each rising edge.
module tb_rf_multiport;

   logic        clk = 1'b0;
   logic        rst;

   logic [7:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic [3:0]  a_wr_addr;
   logic [31:0] a_wr_data;
   logic        a_wr_en;
   logic        a_clr;
   logic        a_busy;

   logic [14:0]  b_rd_addr;
   logic [191:0] b_rd_data;
   logic [4:0]   b_wr_addr;
   logic [63:0]  b_wr_data;
   logic         b_wr_en;
   logic         b_clr;
   logic         b_busy;

   always #5 clk = ~clk;

   rf_multiport dut_a (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (a_rd_addr),
      .rd_data (a_rd_data),
      .wr_addr (a_wr_addr),
      .wr_data (a_wr_data),
      .wr_en   (a_wr_en),
      .clr_req (a_clr),
      .busy    (a_busy)
   );

   rf_multiport #(
      .DATA_W  (64),
      .DEPTH   (32),
      .NRD     (3),
      .ZERO_R0 (0),
      .BYPASS  (0)
   ) dut_b (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (b_rd_addr),
      .rd_data (b_rd_data),
      .wr_addr (b_wr_addr),
      .wr_data (b_wr_data),
      .wr_en   (b_wr_en),
      .clr_req (b_clr),
      .busy    (b_busy)
   );

   // kind: 0 = dut_a rd port, 1 = dut_a busy, 2 = dut_b rd port, 3 = dut_b busy
   typedef struct {
      int          due;
      int          kind;
      int          port;
      logic [63:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   logic [63:0] act;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every queued expectation that is due on this edge.
   always @(posedge clk) begin
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].due == cyc) begin
            case (q[i].kind)
               0:       act = {32'b0, a_rd_data[q[i].port*32 +: 32]};
               1:       act = {63'b0, a_busy};
               2:       act = b_rd_data[q[i].port*64 +: 64];
               default: act = {63'b0, b_busy};
            endcase
            n_chk++;
            if (act === q[i].exp)
               n_pass++;
            else
               $display("FAIL %s port%0d cycle %0d: got %h expected %h",
                        q[i].name, q[i].port, cyc, act, q[i].exp);
            q.delete(i);
         end
      end
   end

   task automatic ex(input int kind, input int port, input logic [63:0] v,
                     input string nm);
      q.push_back('{cyc + 1, kind, port, v, nm});
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Read every dut_a register on both ports, expecting zero everywhere.
   task automatic a_read_all_zero(input string nm);
      a_wr_en = 1'b0;
      a_clr   = 1'b0;
      for (int r = 0; r < 16; r++) begin
         a_rd_addr = {4'(15 - r), 4'(r)};
         ex(0, 0, 64'h0, nm);
         ex(0, 1, 64'h0, nm);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_wr_en = 1'b0; a_clr = 1'b0;
      b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_en = 1'b0; b_clr = 1'b0;
      tick();

      // Reset state
      ex(1, 0, 64'h1, "rst_busy");
      ex(0, 0, 64'h0, "rst_rd");
      ex(0, 1, 64'h0, "rst_rd");
      ex(3, 0, 64'h1, "b_rst_busy");
      tick();
      rst = 1'b0;

      // Power-up clear: dut_a busy for 16 edges, dut_b for 32; writes ignored.
      for (int i = 1; i <= 32; i++) begin
         a_wr_en   = (i <= 16);
         a_wr_addr = 4'd4;
         a_wr_data = 32'h4444_4444;
         a_rd_addr = {4'd4, 4'd4};
         if (i <= 16) begin
            ex(1, 0, 64'(i < 16), "init_busy");
            ex(0, 0, 64'h0, "init_rd");
         end
         ex(3, 0, 64'(i < 32), "b_init_busy");
         tick();
      end
      n_chk++;
      if (a_busy === 1'b0)
         n_pass++;
      else
         $display("FAIL a_idle_after_init: busy=%b", a_busy);
      n_chk++;
      if (b_busy === 1'b0)
         n_pass++;
      else
         $display("FAIL b_idle_after_init: busy=%b", b_busy);
      a_read_all_zero("init_zero");

      // Same-cycle write with bypass on both ports
      a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'hDEAD_BEEF;
      a_rd_addr = {4'd5, 4'd5};
      ex(0, 0, 64'hDEAD_BEEF, "bypass");
      ex(0, 1, 64'hDEAD_BEEF, "bypass");
      tick();
      // Bypass only where the addresses match
      a_wr_addr = 4'd7; a_wr_data = 32'h1111_1111;
      a_rd_addr = {4'd7, 4'd6};
      ex(0, 0, 64'h0, "no_bypass_other");
      ex(0, 1, 64'h1111_1111, "bypass_p1");
      tick();
      a_wr_en = 1'b0;
      a_rd_addr = {4'd7, 4'd5};
      ex(0, 0, 64'hDEAD_BEEF, "stored_r5");
      ex(0, 1, 64'h1111_1111, "stored_r7");
      tick();

      // R0 protection
      a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 32'h1234_5678;
      a_rd_addr = {4'd0, 4'd0};
      ex(0, 0, 64'h0, "r0_bypass");
      ex(0, 1, 64'h0, "r0_bypass");
      tick();
      a_wr_en = 1'b0;
      ex(0, 0, 64'h0, "r0_read");
      ex(0, 1, 64'h0, "r0_read");
      tick();

      // dut_b: no bypass, old value in the write cycle, new value after
      b_wr_en = 1'b1; b_wr_addr = 5'd31; b_wr_data = 64'hFFFF_FFFF_0000_0001;
      b_rd_addr = {5'd31, 5'd31, 5'd31};
      for (int p = 0; p < 3; p++) ex(2, p, 64'h0, "b_nobypass_old");
      tick();
      b_wr_en = 1'b0;
      for (int p = 0; p < 3; p++) ex(2, p, 64'hFFFF_FFFF_0000_0001, "b_r31");
      tick();
      // dut_b: R0 is an ordinary register
      b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 64'h1234_5678;
      b_rd_addr = {5'd31, 5'd0, 5'd0};
      ex(2, 0, 64'h0, "b_r0_old");
      ex(2, 1, 64'h0, "b_r0_old");
      ex(2, 2, 64'hFFFF_FFFF_0000_0001, "b_r31_again");
      tick();
      b_wr_en = 1'b0;
      b_rd_addr = {5'd5, 5'd0, 5'd0};
      ex(2, 0, 64'h1234_5678, "b_r0_written");
      ex(2, 1, 64'h1234_5678, "b_r0_written");
      ex(2, 2, 64'h0, "b_r5_zero");
      tick();

      // Fill dut_a R1..R15 with their index
      for (int r = 1; r < 16; r++) begin
         a_wr_en = 1'b1; a_wr_addr = 4'(r); a_wr_data = 32'(r);
         tick();
      end
      a_wr_en = 1'b0;
      a_rd_addr = {4'd15, 4'd3};
      ex(0, 0, 64'd3, "fill_r3");
      ex(0, 1, 64'd15, "fill_r15");
      tick();

      // Clear request with a colliding write to R3 (dropped, not forwarded)
      a_clr = 1'b1; a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 32'hFF;
      ex(0, 0, 64'd3, "clr_drop_wr");
      ex(0, 1, 64'd15, "clr_edge_rd");
      ex(1, 0, 64'h1, "clr_busy");
      tick();
      for (int i = 1; i <= 16; i++) begin
         a_clr = (i == 5);
         a_wr_data = 32'hAB;
         ex(1, 0, 64'(i < 16), "clr_busy");
         ex(0, 0, 64'h0, "clr_rd");
         tick();
      end
      n_chk++;
      if (a_busy === 1'b0)
         n_pass++;
      else
         $display("FAIL a_idle_after_clr: busy=%b", a_busy);
      a_read_all_zero("clr_zero");

      // Reset in the middle of a clear
      a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 32'h99;
      tick();
      a_wr_en = 1'b0;
      a_clr = 1'b1;
      ex(1, 0, 64'h1, "mid_busy");
      tick();
      a_clr = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         ex(1, 0, 64'h1, "mid_busy");
         tick();
      end
      rst = 1'b1;
      ex(1, 0, 64'h1, "mid_rst_busy");
      tick();
      ex(1, 0, 64'h1, "mid_rst_busy");
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         ex(1, 0, 64'(i < 16), "rerun_busy");
         tick();
      end
      n_chk++;
      if (a_busy === 1'b0)
         n_pass++;
      else
         $display("FAIL a_idle_after_rerun: busy=%b", a_busy);
      a_read_all_zero("rerun_zero");

      repeat (3) tick();
      // Anything still queued was never observed.
      while (q.size() > 0) begin
         n_chk++;
         $display("FAIL %s: expectation for cycle %0d never checked", q[0].name, q[0].due);
         void'(q.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      if (n_pass == n_chk)
         $display("PASS");
      else
         $display("FAIL: %0d checks failed", n_chk - n_pass);
      $finish;
   end

endmodule
